duty_cycle_meter: RTL and testbench

DUTY_CYCLE_METER -- requirements
Module: duty_cycle_meter

---
 rtl/duty_cycle_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 33 +++
 rtl/duty_cycle_meter.sv | 126 ++++++++++++
 tb/tb_duty_cycle_meter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/duty_cycle_pkg.sv
// Shared types and default parameters for the duty-cycle meter.
package duty_cycle_pkg;

  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    WAIT_RISE,
    HIGH,
    LOW
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronises an asynchronous input and flags its rising/falling edges.
module sync_edge_det
  import duty_cycle_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_d_q;
  logic                   sig_s;

  // Synchroniser chain plus one delayed copy of the synchronised level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      sig_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_d_q;
  assign fall  = ~sig_s & sig_d_q;

endmodule

// File: rtl/duty_cycle_meter.sv
// Measures high time and period of sig_in in clk cycles, rise to rise.
module duty_cycle_meter
  import duty_cycle_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] meas_high,
  output logic [CNT_W-1:0] meas_period,
  output logic             meas_valid,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic rise, fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] mh_q, mh_d;
  logic [CNT_W-1:0] mp_q, mp_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .sig_in(sig_in),
    .rise  (rise),
    .fall  (fall)
  );

  // State, counters and measurement registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_RISE;
      hi_q    <= '0;
      per_q   <= '0;
      mh_q    <= '0;
      mp_q    <= '0;
      valid_q <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      per_q   <= per_d;
      mh_q    <= mh_d;
      mp_q    <= mp_d;
      valid_q <= valid_d;
      stuck_q <= stuck_d;
    end
  end

  // Next-state and counting; a saturating period count aborts to WAIT_RISE.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    per_d   = per_q;
    mh_d    = mh_q;
    mp_d    = mp_q;
    valid_d = 1'b0;
    stuck_d = stuck_q;
    unique case (state_q)
      WAIT_RISE: begin
        hi_d  = '0;
        per_d = '0;
        if (rise) begin
          state_d = HIGH;
          hi_d    = CNT_ONE;
          per_d   = CNT_ONE;
        end
      end
      HIGH: begin
        if (per_q == CNT_MAX) begin
          state_d = WAIT_RISE;
          hi_d    = '0;
          per_d   = '0;
          stuck_d = 1'b1;
        end else if (fall) begin
          state_d = LOW;
          per_d   = per_q + CNT_ONE;
        end else begin
          per_d = per_q + CNT_ONE;
          hi_d  = hi_q + CNT_ONE;
        end
      end
      LOW: begin
        // A rise closes the period without incrementing, so it wins over overflow.
        if (rise) begin
          mh_d    = hi_q;
          mp_d    = per_q;
          valid_d = 1'b1;
          stuck_d = 1'b0;
          hi_d    = CNT_ONE;
          per_d   = CNT_ONE;
          state_d = HIGH;
        end else if (per_q == CNT_MAX) begin
          state_d = WAIT_RISE;
          hi_d    = '0;
          per_d   = '0;
          stuck_d = 1'b1;
        end else begin
          per_d = per_q + CNT_ONE;
        end
      end
      default: begin
        state_d = WAIT_RISE;
        hi_d    = '0;
        per_d   = '0;
      end
    endcase
  end

  assign meas_high   = mh_q;
  assign meas_period = mp_q;
  assign meas_valid  = valid_q;
  assign stuck       = stuck_q;

endmodule

// File: tb/tb_duty_cycle_meter.sv
// Randomised and directed bench for duty_cycle_meter, two configurations in parallel.
module tb_duty_cycle_meter;

  localparam int unsigned W0 = 16;
  localparam int unsigned S0 = 2;
  localparam int unsigned W1 = 4;
  localparam int unsigned S1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_in = 1'b0;

  logic [W0-1:0] mh0, mp0;
  logic          mv0, st0;
  logic [W1-1:0] mh1, mp1;
  logic          mv1, st1;

  always #5 clk = ~clk;

  duty_cycle_meter #(.CNT_W(W0), .SYNC_STAGES(S0)) u0 (
    .clk(clk), .rst(rst), .sig_in(sig_in),
    .meas_high(mh0), .meas_period(mp0), .meas_valid(mv0), .stuck(st0)
  );

  duty_cycle_meter #(.CNT_W(W1), .SYNC_STAGES(S1)) u1 (
    .clk(clk), .rst(rst), .sig_in(sig_in),
    .meas_high(mh1), .meas_period(mp1), .meas_valid(mv1), .stuck(st1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcnt0 = 0;
  int vcnt1 = 0;
  bit run_chk = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: sample history, cycles since last synchronised rise and
  // number of high cycles since that rise.
  int  m_s[2]   = '{S0, S1};
  int  m_max[2] = '{(1 << W0) - 1, (1 << W1) - 1};
  bit  sh[2][8];
  bit  have[2];
  int  e[2], ones[2];
  int  eh[2], ep[2];
  bit  ev[2], es[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 8; j++) sh[i][j] = 1'b0;
      have[i] = 1'b0; e[i] = 0; ones[i] = 0;
      eh[i] = 0; ep[i] = 0; ev[i] = 1'b0; es[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i);
    bit s, d, r;
    for (int j = 7; j > 0; j--) sh[i][j] = sh[i][j-1];
    sh[i][0] = sig_in;
    s = sh[i][m_s[i]];
    d = sh[i][m_s[i] + 1];
    r = s && !d;
    ev[i] = 1'b0;
    if (have[i] && r) begin
      eh[i] = ones[i]; ep[i] = e[i]; ev[i] = 1'b1; es[i] = 1'b0;
    end else if (have[i] && e[i] == m_max[i]) begin
      es[i] = 1'b1; have[i] = 1'b0;
    end
    if (r) begin
      have[i] = 1'b1; e[i] = 1; ones[i] = 1;
    end else if (have[i]) begin
      e[i]++; ones[i] += int'(s);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) model_reset();
    else for (int i = 0; i < 2; i++) model_step(i);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (run_chk) begin
      if (mv0) vcnt0++;
      if (mv1) vcnt1++;
      if (rst) begin
        check("rst_mh0", mh0, 0); check("rst_mp0", mp0, 0);
        check("rst_mv0", mv0, 0); check("rst_st0", st0, 0);
        check("rst_mh1", mh1, 0); check("rst_mp1", mp1, 0);
        check("rst_mv1", mv1, 0); check("rst_st1", st1, 0);
      end else begin
        check("mh0", mh0, eh[0]); check("mp0", mp0, ep[0]);
        check("mv0", mv0, ev[0]); check("st0", st0, es[0]);
        check("mh1", mh1, eh[1]); check("mp1", mp1, ep[1]);
        check("mv1", mv1, ev[1]); check("st1", st1, es[1]);
        if (mv0) check("range0", (mh0 != 0 && mh0 < mp0), 1);
        if (mv1) check("range1", (mh1 != 0 && mh1 < mp1), 1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(posedge clk);
      #2 sig_in = v;
    end
  endtask

  task automatic wave(input int h, input int l, input int count);
    repeat (count) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  task automatic settle();
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kc, lat0, lat1, vsave;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("init_mh0", mh0, 0); check("init_mp0", mp0, 0);
    check("init_mv0", mv0, 0); check("init_st0", st0, 0);

    // 25% wave: 1 high, 3 low
    vcnt0 = 0; vcnt1 = 0;
    wave(1, 3, 8);
    settle();
    check("q_mh0", mh0, 1); check("q_mp0", mp0, 4);
    check("q_mh1", mh1, 1); check("q_mp1", mp1, 4);
    check("q_cnt0", vcnt0, 7); check("q_cnt1", vcnt1, 7);

    // 4/4 then 2/6
    wave(4, 4, 4);
    settle();
    check("h_mh0", mh0, 4); check("h_mp0", mp0, 8);
    wave(2, 6, 2);
    settle();
    check("t_mh0", mh0, 2); check("t_mp0", mp0, 8);
    check("t_mh1", mh1, 2); check("t_mp1", mp1, 8);

    // single-cycle pulse every 10 cycles, with latency probe
    wave(1, 9, 3);
    lat0 = -1; lat1 = -1;
    @(posedge clk);
    #2 sig_in = 1'b1;
    @(posedge clk);
    #1 kc = cyc;
    #1 sig_in = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      #1;
      if (mv0 && lat0 < 0) lat0 = cyc - kc;
      if (mv1 && lat1 < 0) lat1 = cyc - kc;
    end
    check("lat_s2", lat0, S0);
    check("lat_s3", lat1, S1);
    wave(1, 9, 2);
    settle();
    check("p_mh0", mh0, 1); check("p_mp0", mp0, 10);
    check("p_mh1", mh1, 1); check("p_mp1", mp1, 10);

    // hold high: narrow instance saturates and flags stuck
    vsave = vcnt1;
    drive(1'b0, 3);
    drive(1'b1, 30);
    settle();
    check("s_st1", st1, 1); check("s_st0", st0, 0);
    check("s_mh1", mh1, 1); check("s_mp1", mp1, 10);
    check("s_nov1", vcnt1, vsave);
    drive(1'b0, 2);
    wave(2, 2, 1);
    #1;
    check("s_hold1", st1, 1);
    wave(2, 2, 3);
    settle();
    check("s_clr1", st1, 0); check("s_mh1b", mh1, 2); check("s_mp1b", mp1, 4);

    // reset in the middle of the low phase
    wave(4, 4, 3);
    drive(1'b1, 4);
    drive(1'b0, 4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("r_mh0", mh0, 0); check("r_mp0", mp0, 0);
    check("r_mh1", mh1, 0); check("r_mp1", mp1, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    vcnt0 = 0; vcnt1 = 0;
    drive(1'b0, 2);
    wave(4, 4, 1);
    settle();
    check("r_first0", vcnt0, 0); check("r_first1", vcnt1, 0);
    wave(4, 4, 1);
    settle();
    check("r_second0", vcnt0, 1); check("r_second1", vcnt1, 1);

    // randomised periods; long ones exercise the narrow counter's stuck path
    repeat (80) begin
      wave($urandom_range(1, 12), $urandom_range(1, 12), 1);
    end
    settle();

    run_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
